branch_stat_monitor: RTL

Consumer for the core's branch-observation signals (branch-resolved strobe, misprediction strobe, fetched instruction). It accumulates whole-run totals, emits fixed-length window records through a small valid/ready FIFO, and stops at the program halt instruction. It sits in the testbench or FPGA debug wrapper beside the pipelined core and reads the predictor's statistics outputs.

---
 rtl/branch_stat_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/branch_stat_monitor.sv
// rtl/branch_stat_monitor.sv - branch statistics monitor: run totals, windowed records via FIFO, halt detection
module branch_stat_monitor #(
  parameter int          CNT_W      = 32,
  parameter int          WINDOW     = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             br_instr_i,
  input  logic             br_miss_i,
  input  logic [31:0]      instr_i,
  output logic             rec_valid_o,
  input  logic             rec_ready_i,
  output logic [CNT_W-1:0] rec_br_o,
  output logic [CNT_W-1:0] rec_miss_o,
  output logic             rec_last_o,
  output logic [CNT_W-1:0] tot_br_o,
  output logic [CNT_W-1:0] tot_miss_o,
  output logic [CNT_W-1:0] tot_cyc_o,
  output logic [15:0]      drop_cnt_o,
  output logic             done_o
);

  localparam int WC_W = $clog2(WINDOW);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  state_t            state, state_nx;
  logic [WC_W-1:0]   win_cyc;
  logic [CNT_W-1:0]  win_br, win_miss;
  logic [CNT_W-1:0]  win_br_nx, win_miss_nx;
  logic [CNT_W-1:0]  tot_br, tot_miss, tot_cyc;
  logic [15:0]       drop_cnt;

  logic [CNT_W-1:0]  mem_br   [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_miss [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic              counted, win_end, halt, pop, full, can_push;
  logic              push, push_last, drop, win_clr;
  logic [CNT_W-1:0]  push_br, push_miss;

  assign counted     = enable_i && (state == S_IDLE || state == S_RUN);
  assign win_end     = counted && (win_cyc == WIN_LAST);
  assign halt        = counted && (instr_i == HALT_INSTR);
  assign win_br_nx   = sat_inc(win_br, br_instr_i);
  assign win_miss_nx = sat_inc(win_miss, br_instr_i && br_miss_i);

  assign rec_valid_o = (count != '0);
  assign pop         = rec_valid_o && rec_ready_i;
  assign full        = (count == FIFO_FULL);
  assign can_push    = !full || pop;

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_last = 1'b0;
    push_br   = win_br_nx;
    push_miss = win_miss_nx;
    drop      = 1'b0;
    win_clr   = 1'b0;
    case (state)
      S_IDLE, S_RUN: begin
        if (counted) begin
          state_nx = S_RUN;
          if (halt) begin
            // A halt on a window boundary with a full FIFO falls back to FLUSH so the last record survives.
            if (win_end && can_push) begin
              push      = 1'b1;
              push_last = 1'b1;
              win_clr   = 1'b1;
              state_nx  = S_DONE;
            end else begin
              state_nx = S_FLUSH;
            end
          end else if (win_end) begin
            win_clr = 1'b1;
            if (can_push) push = 1'b1;
            else          drop = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        push_br   = win_br;
        push_miss = win_miss;
        push_last = 1'b1;
        if (can_push) begin
          push     = 1'b1;
          state_nx = S_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      win_cyc  <= '0;
      win_br   <= '0;
      win_miss <= '0;
      tot_br   <= '0;
      tot_miss <= '0;
      tot_cyc  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (counted) begin
        win_cyc  <= win_end ? '0 : win_cyc + WC_W'(1);
        win_br   <= win_clr ? '0 : win_br_nx;
        win_miss <= win_clr ? '0 : win_miss_nx;
        tot_br   <= sat_inc(tot_br, br_instr_i);
        tot_miss <= sat_inc(tot_miss, br_instr_i && br_miss_i);
        tot_cyc  <= sat_inc(tot_cyc, 1'b1);
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_br[wr_ptr]   <= push_br;
      mem_miss[wr_ptr] <= push_miss;
      mem_last[wr_ptr] <= push_last;
    end
  end

  // Record fields read as zero when the FIFO is empty, so stale storage never shows after reset.
  assign rec_br_o   = rec_valid_o ? mem_br[rd_ptr]   : '0;
  assign rec_miss_o = rec_valid_o ? mem_miss[rd_ptr] : '0;
  assign rec_last_o = rec_valid_o ? mem_last[rd_ptr] : 1'b0;

  assign tot_br_o   = tot_br;
  assign tot_miss_o = tot_miss;
  assign tot_cyc_o  = tot_cyc;
  assign drop_cnt_o = drop_cnt;
  assign done_o     = (state == S_DONE);

endmodule
